// File: rtl/boot_loader_pkg.sv
// Shared state encoding and memory-port constants for the boot loader.
// StVerify exists only when BOOT_LOADER_READBACK_EN is defined.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCount,
        StData,
        StCsum,
        StRun,
        StError
`ifdef BOOT_LOADER_READBACK_EN
        , StVerify
`endif
    } boot_state_e;

    localparam logic [7:0] SyncDefault = 8'hA5;

    // Word address is 17 bits, carried on ports numbered [15:31] with bit 31 as LSB.
    localparam int unsigned AddrWidth = 17;
    localparam int unsigned AddrMsb   = 15;
    localparam int unsigned AddrLsb   = 31;

    localparam logic [3:0] WeAll  = 4'b1111;
    localparam logic [3:0] WeNone = 4'b0000;

    function automatic logic addr_in_range(input logic [23:0] frame_addr);
        return frame_addr[23:AddrWidth] == '0;
    endfunction

endpackage

// File: rtl/boot_frame_checksum.sv
// Running 8-bit frame checksum: cleared on SYNC, accumulates each frame byte,
// and reports whether the current byte brings the total to zero.
module boot_frame_checksum (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic       sum_zero
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_zero = (sum_q + data) == 8'd0;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: holds the CPU in reset, loads a framed image into memory, then releases it.
// Defining BOOT_LOADER_READBACK_EN adds a verify cycle after every word write.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SyncDefault,
    parameter bit         BOOT_BYPASS = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [0:7]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   reload,
    input  logic [AddrMsb:AddrLsb] cpu_address,
    input  logic [0:31]            cpu_data_out,
    input  logic [0:3]             cpu_wr_enables,
    output logic [AddrMsb:AddrLsb] mem_address,
    output logic [0:31]            mem_data_out,
    output logic [0:3]             mem_wr_enables,
    input  logic [0:31]            mem_data_in,
    output logic                   cpu_reset,
    output logic                   load_busy,
    output logic                   load_error,
    output logic [0:15]            words_loaded
);

    localparam boot_state_e ResetState = BOOT_BYPASS ? StRun : StIdle;

    boot_state_e          state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [15:0]          addr_hi_q, addr_hi_d;
    logic [AddrWidth-1:0] load_addr_q, load_addr_d;
    logic [15:0]          count_q, count_d;
    logic [15:0]          words_q, words_d;
    logic [23:0]          word_sr_q, word_sr_d;
    logic                 wr_pending_q, wr_pending_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 load_error_q, load_error_d;
    logic                 cpu_reset_q, cpu_reset_d;

    logic [7:0]  in_byte;
    logic        accept;
    logic [23:0] full_addr;
    logic [15:0] count_next;
    logic        sum_clear, sum_add, sum_zero;

    assign in_byte    = in_data;
    assign accept     = in_valid & in_ready;
    assign full_addr  = {addr_hi_q, in_byte};
    assign count_next = {count_q[7:0], in_byte};

`ifdef BOOT_LOADER_READBACK_EN
    boot_state_e ret_q, ret_d;
`else
    logic unused_mem_data_in;
    assign unused_mem_data_in = ^mem_data_in;
`endif

    boot_frame_checksum u_checksum (
        .clock    (clock),
        .reset    (reset),
        .clear    (sum_clear),
        .add      (sum_add),
        .data     (in_byte),
        .sum_zero (sum_zero)
    );

    always_comb begin
        in_ready = 1'b1;
        unique case (state_q)
            StRun:    in_ready = 1'b0;
`ifdef BOOT_LOADER_READBACK_EN
            StVerify: in_ready = 1'b0;
`endif
            default:  in_ready = 1'b1;
        endcase
`ifdef BOOT_LOADER_READBACK_EN
        // During a write cycle only a fresh data byte may be taken; CSUM waits for the verify.
        if (wr_pending_q && state_q != StData) begin
            in_ready = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        addr_hi_d    = addr_hi_q;
        load_addr_d  = load_addr_q;
        count_d      = count_q;
        words_d      = words_q;
        word_sr_d    = word_sr_q;
        wr_pending_d = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_error_d = load_error_q;
        cpu_reset_d  = (state_q != StRun) || reload;
        sum_clear    = 1'b0;
        sum_add      = 1'b0;
`ifdef BOOT_LOADER_READBACK_EN
        ret_d        = ret_q;
`endif

        unique case (state_q)
            StIdle, StError: begin
                if (accept && in_byte == SYNC_BYTE) begin
                    state_d      = StAddr;
                    byte_cnt_d   = '0;
                    load_error_d = 1'b0;
                    words_d      = '0;
                    sum_clear    = 1'b1;
                end
            end
            StAddr: begin
                if (accept) begin
                    sum_add = 1'b1;
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d  = '0;
                        load_addr_d = full_addr[AddrWidth-1:0];
                        state_d     = addr_in_range(full_addr) ? StCount : StError;
                    end else begin
                        addr_hi_d  = {addr_hi_q[7:0], in_byte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StCount: begin
                if (accept) begin
                    sum_add = 1'b1;
                    count_d = count_next;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = '0;
                        state_d    = (count_next == '0) ? StCsum : StData;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    sum_add = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_pending_d = 1'b1;
                        wr_addr_d    = load_addr_q;
                        wr_data_d    = {word_sr_q, in_byte};
                        load_addr_d  = load_addr_q + 1'b1;
                        words_d      = words_q + 16'd1;
                        byte_cnt_d   = '0;
                        if (words_q + 16'd1 == count_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        word_sr_d  = {word_sr_q[15:0], in_byte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    sum_add = 1'b1;
                    state_d = sum_zero ? StRun : StError;
                end
            end
            StRun: begin
                if (reload) begin
                    state_d = StIdle;
                end
            end
`ifdef BOOT_LOADER_READBACK_EN
            StVerify: begin
                state_d = (mem_data_in == wr_data_q) ? ret_q : StError;
            end
`endif
            default: state_d = StIdle;
        endcase

`ifdef BOOT_LOADER_READBACK_EN
        if (wr_pending_q) begin
            ret_d   = state_d;
            state_d = StVerify;
        end
`endif

        if (state_d == StError) begin
            load_error_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ResetState;
            byte_cnt_q   <= '0;
            addr_hi_q    <= '0;
            load_addr_q  <= '0;
            count_q      <= '0;
            words_q      <= '0;
            word_sr_q    <= '0;
            wr_pending_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_error_q <= 1'b0;
            cpu_reset_q  <= ~BOOT_BYPASS;
`ifdef BOOT_LOADER_READBACK_EN
            ret_q        <= StIdle;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_hi_q    <= addr_hi_d;
            load_addr_q  <= load_addr_d;
            count_q      <= count_d;
            words_q      <= words_d;
            word_sr_q    <= word_sr_d;
            wr_pending_q <= wr_pending_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_error_q <= load_error_d;
            cpu_reset_q  <= cpu_reset_d;
`ifdef BOOT_LOADER_READBACK_EN
            ret_q        <= ret_d;
`endif
        end
    end

    // Memory port belongs to the CPU only in RUN; otherwise the loader owns it.
    always_comb begin
        if (state_q == StRun) begin
            mem_address    = cpu_address;
            mem_data_out   = cpu_data_out;
            mem_wr_enables = cpu_wr_enables;
        end else begin
            mem_address    = wr_addr_q;
            mem_data_out   = wr_data_q;
            mem_wr_enables = wr_pending_q ? WeAll : WeNone;
        end
    end

    assign cpu_reset    = cpu_reset_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;
    assign load_busy    = state_q inside {StAddr, StCount, StData, StCsum
`ifdef BOOT_LOADER_READBACK_EN
                                          , StVerify
`endif
                                          };

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits upstream of the CPU, between a byte-stream source (UART receiver) and the shared memory port.
- Holds the CPU in reset and receives a framed program image byte by byte. Assembles big-endian 32-bit words and writes them into memory.
- On a good checksum, hands the memory port to the CPU and releases it from reset.
- Memory is zero-latency combinational read, with per-byte write enables. Enable bit 0 selects bits 0:7.

Parameters:
- SYNC_BYTE, 8'hA5, frame header byte.
- BOOT_BYPASS, 0, if 1 the block leaves reset directly in RUN (CPU released, no load).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- in_data  input  [0:7]  stream byte, bit 0 MSB
- in_valid  input  1  byte available
- in_ready  output  1  byte accepted when in_valid & in_ready
- reload  input  1  single-cycle request to re-enter load mode
- cpu_address  input  [15:31]  CPU word address
- cpu_data_out  input  [0:31]  CPU write data
- cpu_wr_enables  input  [0:3]  CPU byte write enables
- mem_address  output  [15:31]  to memory
- mem_data_out  output  [0:31]  to memory
- mem_wr_enables  output  [0:3]  to memory
- mem_data_in  input  [0:31]  memory read data (used only by the optional feature)
- cpu_reset  output  1  drives CPU reset
- load_busy  output  1  frame in progress (ADDR..CSUM)
- load_error  output  1  sticky error flag
- words_loaded  output  [0:15]  words written in the current frame

Behaviour:
- Reset is asynchronous, active-high; clock is clock. Values in reset:
  - state = IDLE, or RUN if BOOT_BYPASS.
  - cpu_reset = 1 (0 if bypass); load_error = 0; words_loaded = 0; internal mem write enables = 0.
- Frame format: SYNC, ADDR (3 bytes big-endian), COUNT (2 bytes big-endian), COUNT×4 data bytes, CSUM (1 byte).
  - Valid when the 8-bit sum of every byte after SYNC, including CSUM, equals 0 mod 256.
- States: IDLE, ADDR, COUNT, DATA, CSUM, RUN, ERROR.
  - IDLE: in_ready = 1. A byte equal to SYNC goes to ADDR, clears load_error and words_loaded, and clears the checksum accumulator. Any other byte is discarded.
  - ADDR: collect 3 bytes. After the 3rd byte, if address bits 23:17 ≠ 0, go to ERROR; else go to COUNT.
  - COUNT: collect 2 bytes. A count of 0 goes to CSUM; otherwise go to DATA.
  - DATA: shift bytes into the word register MSB first.
    - On the 4th byte, register a write for the next cycle: mem_wr_enables = 4'b1111, address = current load address, data = assembled word.
    - Then increment the load address mod 2^17 and increment words_loaded.
    - After the last word, go to CSUM.
    - in_ready stays 1; one byte per cycle is sustained.
  - CSUM: a good sum goes to RUN; a bad sum goes to ERROR.
  - RUN: in_ready = 0. cpu_reset deasserts on the cycle after entering RUN (registered).
  - RUN + reload: cpu_reset = 1 immediately (registered, next edge); go to IDLE.
  - ERROR: load_error = 1, cpu_reset = 1, in_ready = 1. Bytes are discarded until SYNC, which behaves as in IDLE.
- Memory mux (combinational on the state register):
  - RUN: mem_* = cpu_*.
  - All other states: mem_* are driven by the loader. mem_wr_enables = 0 except on the registered write cycle.
  - CPU write enables are ignored outside RUN.
- Memory already written by a frame that later fails its checksum is not rolled back.
- Reset mid-frame: state returns to IDLE, any pending write is cancelled, and cpu_reset = 1.
- reload outside RUN is ignored.

Optional Feature:
- Macro: BOOT_LOADER_READBACK_EN.
- When defined:
  - Each write cycle is followed by a VERIFY cycle: same address, enables 0, in_ready = 0.
  - mem_data_in is compared with the written word; a mismatch goes to ERROR.
  - Sustained throughput becomes 4 bytes per 5 cycles.
- When undefined: there is no VERIFY state and mem_data_in is unused.

Decomposition:
- Shared package holds:
  - state encodings;
  - the SYNC default;
  - address width 17 and its bounds;
  - the memory-select style constants reused with the CPU.
- One sub-module is natural: boot_frame_checksum (8-bit accumulator, clear/add/zero-check).
- Byte assembly and the mux stay in the top module.

Test Plan:
- Good 2-word frame: A5 00 01 00 00 02 22 10 00 05 2E 00 00 00 98.
  - Writes 0x22100005 at word 0x00100 and 0x2E000000 at 0x00101.
  - words_loaded = 2; cpu_reset drops the cycle after CSUM; mem_* then follow cpu_*.
- Same frame with CSUM = 0x99 → load_error = 1, cpu_reset stays 1, both words still written. A following good frame clears load_error.
- Address byte 0x02 in the high position (bit 17 set) → ERROR after the 3rd address byte; no write occurs.
- COUNT = 0, CSUM = 0x00 with address 0 → RUN with no write cycles.
- Reset asserted after 2 data bytes → IDLE, cpu_reset = 1, no write. A full frame then loads correctly.
- In RUN, pulse reload → cpu_reset = 1 next cycle; cpu_wr_enables = 4'b1111 is blocked from memory. A new frame loads.
